// File: rtl/exc_req_ctrl.sv
// Exception request controller: captures the highest-priority MEM-stage exception,
// reports it to the coprocessor, waits for acknowledge, then flushes and redirects fetch.
module exc_req_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_m,
  input  logic        stall_in,
  input  logic [31:0] pc_m,
  input  logic        dslot_m,
  input  logic [31:0] addr_m,
  input  logic        adel_if,
  input  logic        ri_m,
  input  logic        sys_m,
  input  logic        bp_m,
  input  logic        ov_m,
  input  logic        adel_m,
  input  logic        ades_m,
  input  logic        eret_m,
  input  logic        int_pending,
  input  logic        except_deal,
  input  logic [31:0] epc_in,
  output logic [4:0]  exccode_o,
  output logic [31:0] badaddr_o,
  output logic        dslot_o,
  output logic [31:0] pc_o,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy,
  output logic        ack_err
);

  typedef enum logic [1:0] {IDLE, REPORT, WAIT_ACK, REDIRECT} state_t;

  localparam logic [4:0]  CODE_NONE = 5'h1F;
  localparam logic [31:0] EXC_VECTOR = 32'hBFC00380;

  state_t      state, state_next;
  logic [1:0]  wait_cnt;
  logic        is_eret;
  logic [31:0] epc_q;
  logic        any_req, capture;
  logic [4:0]  win_code;
  logic [31:0] win_badaddr;
  logic        win_eret;

  assign any_req = int_pending | adel_if | ri_m | sys_m | bp_m | ov_m |
                   adel_m | ades_m | eret_m;
  assign capture = valid_m & ~stall_in & (state == IDLE) & any_req;

  // Interrupts report NONE because the coprocessor raises Int on its own
  always_comb begin
    win_code    = CODE_NONE;
    win_badaddr = 32'h0;
    win_eret    = 1'b0;
    if (int_pending) begin
      win_code = CODE_NONE;
    end else if (adel_if) begin
      win_code    = 5'h04;
      win_badaddr = pc_m;
    end else if (ri_m) begin
      win_code = 5'h0A;
    end else if (sys_m) begin
      win_code = 5'h08;
    end else if (bp_m) begin
      win_code = 5'h09;
    end else if (ov_m) begin
      win_code = 5'h0C;
    end else if (adel_m) begin
      win_code    = 5'h04;
      win_badaddr = addr_m;
    end else if (ades_m) begin
      win_code    = 5'h05;
      win_badaddr = addr_m;
    end else if (eret_m) begin
      win_code = 5'h0E;
      win_eret = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    ack_err    = 1'b0;
    case (state)
      IDLE:     if (capture) state_next = REPORT;
      REPORT:   state_next = WAIT_ACK;
      WAIT_ACK: begin
        if (except_deal) begin
          state_next = REDIRECT;
        end else if (wait_cnt == 2'd3) begin
          ack_err    = 1'b1;
          state_next = IDLE;
        end
      end
      REDIRECT: state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Report fields load on capture and clear whenever the FSM falls back to IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= 2'd0;
      exccode_o <= CODE_NONE;
      badaddr_o <= 32'h0;
      pc_o      <= 32'h0;
      dslot_o   <= 1'b0;
      is_eret   <= 1'b0;
      epc_q     <= 32'h0;
    end else begin
      state    <= state_next;
      wait_cnt <= (state == WAIT_ACK) ? wait_cnt + 2'd1 : 2'd0;
      if (state == WAIT_ACK && except_deal) epc_q <= epc_in;
      if (capture) begin
        exccode_o <= win_code;
        badaddr_o <= win_badaddr;
        pc_o      <= pc_m;
        dslot_o   <= dslot_m;
        is_eret   <= win_eret;
      end else if (state_next == IDLE) begin
        exccode_o <= CODE_NONE;
        badaddr_o <= 32'h0;
        pc_o      <= 32'h0;
        dslot_o   <= 1'b0;
        is_eret   <= 1'b0;
      end
    end
  end

  assign busy           = (state != IDLE);
  assign flush          = (state == REDIRECT);
  assign redirect_valid = (state == REDIRECT);
  assign redirect_pc    = (state == REDIRECT) ? (is_eret ? epc_q : EXC_VECTOR) : 32'h0;

endmodule

// File: tb/tb_exc_req_ctrl.sv
// Directed self-checking bench for exc_req_ctrl; outputs are sampled 1ns after each rising edge.
module tb_exc_req_ctrl;

  logic        clk, rst, valid_m, stall_in, dslot_m;
  logic [31:0] pc_m, addr_m, epc_in;
  logic        adel_if, ri_m, sys_m, bp_m, ov_m, adel_m, ades_m, eret_m;
  logic        int_pending, except_deal;
  logic [4:0]  exccode_o;
  logic [31:0] badaddr_o, pc_o, redirect_pc;
  logic        dslot_o, flush, redirect_valid, busy, ack_err;

  int errors = 0;
  int checks = 0;

  localparam logic [8:0] F_NONE = 9'h000, F_INT = 9'h100, F_ADEL_IF = 9'h080,
    F_RI = 9'h040, F_SYS = 9'h020, F_BP = 9'h010, F_OV = 9'h008,
    F_ADEL = 9'h004, F_ADES = 9'h002, F_ERET = 9'h001;

  exc_req_ctrl dut (
    .clk(clk), .rst(rst), .valid_m(valid_m), .stall_in(stall_in),
    .pc_m(pc_m), .dslot_m(dslot_m), .addr_m(addr_m),
    .adel_if(adel_if), .ri_m(ri_m), .sys_m(sys_m), .bp_m(bp_m), .ov_m(ov_m),
    .adel_m(adel_m), .ades_m(ades_m), .eret_m(eret_m),
    .int_pending(int_pending), .except_deal(except_deal), .epc_in(epc_in),
    .exccode_o(exccode_o), .badaddr_o(badaddr_o), .dslot_o(dslot_o), .pc_o(pc_o),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .busy(busy), .ack_err(ack_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [8:0] f, input logic v, input logic [31:0] pc,
                               input logic [31:0] addr, input logic ds);
    {int_pending, adel_if, ri_m, sys_m, bp_m, ov_m, adel_m, ades_m, eret_m} = f;
    valid_m = v;
    pc_m    = pc;
    addr_m  = addr;
    dslot_m = ds;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Starting in REPORT with inputs cleared: acknowledge at WAIT_ACK and return to IDLE
  task automatic ackAndDrain;
    step;
    except_deal = 1'b1;
    step;
    except_deal = 1'b0;
    step;
  endtask

  initial begin
    rst = 1'b1; stall_in = 1'b0; except_deal = 1'b0; epc_in = 32'h0;
    applyStimulus(F_NONE, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_exccode", 32'(exccode_o), 32'h1F);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_flush", 32'(flush), 32'h0);
    checkOutput("rst_redirect_pc", redirect_pc, 32'h0);
    checkOutput("rst_pc_o", pc_o, 32'h0);
    rst = 1'b0;

    // Overflow, ack at T+2, flush at T+3
    applyStimulus(F_OV, 1'b1, 32'h80001000, 32'h0, 1'b0);
    step;
    checkOutput("ov_exccode", 32'(exccode_o), 32'h0C);
    checkOutput("ov_pc_o", pc_o, 32'h80001000);
    checkOutput("ov_dslot", 32'(dslot_o), 32'h0);
    checkOutput("ov_busy", 32'(busy), 32'h1);
    applyStimulus(F_NONE, 1'b0, 32'h0, 32'h0, 1'b0);
    step;
    checkOutput("ov_flush_t2", 32'(flush), 32'h0);
    except_deal = 1'b1;
    step;
    except_deal = 1'b0;
    checkOutput("ov_flush_t3", 32'(flush), 32'h1);
    checkOutput("ov_redirect_valid", 32'(redirect_valid), 32'h1);
    checkOutput("ov_redirect_pc", redirect_pc, 32'hBFC00380);
    checkOutput("ov_exccode_t3", 32'(exccode_o), 32'h0C);
    step;
    checkOutput("ov_flush_t4", 32'(flush), 32'h0);
    checkOutput("ov_busy_t4", 32'(busy), 32'h0);
    checkOutput("ov_exccode_idle", 32'(exccode_o), 32'h1F);
    checkOutput("ov_pc_idle", pc_o, 32'h0);

    // RI beats AdEL data
    applyStimulus(F_RI | F_ADEL, 1'b1, 32'h80000100, 32'h00000003, 1'b0);
    step;
    checkOutput("ri_exccode", 32'(exccode_o), 32'h0A);
    checkOutput("ri_badaddr", badaddr_o, 32'h0);
    applyStimulus(F_NONE, 1'b0, 32'h0, 32'h0, 1'b0);
    ackAndDrain;

    // AdES in delay slot, with a second request held while busy
    applyStimulus(F_ADES, 1'b1, 32'h80000204, 32'h80000006, 1'b1);
    step;
    checkOutput("ades_exccode", 32'(exccode_o), 32'h05);
    checkOutput("ades_badaddr", badaddr_o, 32'h80000006);
    checkOutput("ades_dslot", 32'(dslot_o), 32'h1);
    checkOutput("ades_pc_o", pc_o, 32'h80000204);
    applyStimulus(F_SYS, 1'b1, 32'h80000300, 32'h0, 1'b0);
    step;
    except_deal = 1'b1;
    step;
    except_deal = 1'b0;
    applyStimulus(F_NONE, 1'b0, 32'h0, 32'h0, 1'b0);
    checkOutput("busy_req_ignored_code", 32'(exccode_o), 32'h05);
    checkOutput("busy_req_ignored_pc", pc_o, 32'h80000204);
    step;
    checkOutput("busy_req_not_queued", 32'(busy), 32'h0);
    step;
    checkOutput("busy_req_not_queued2", 32'(busy), 32'h0);

    // ERET redirects to the EPC sampled at acknowledge
    applyStimulus(F_ERET, 1'b1, 32'h80000400, 32'h0, 1'b0);
    step;
    checkOutput("eret_exccode", 32'(exccode_o), 32'h0E);
    applyStimulus(F_NONE, 1'b0, 32'h0, 32'h0, 1'b0);
    step;
    except_deal = 1'b1;
    epc_in = 32'h80002000;
    step;
    except_deal = 1'b0;
    epc_in = 32'h12345678;
    checkOutput("eret_redirect_pc", redirect_pc, 32'h80002000);
    checkOutput("eret_flush", 32'(flush), 32'h1);
    step;

    // Interrupt beats ERET and reports NONE; ack during REPORT is ignored
    applyStimulus(F_INT | F_ERET, 1'b1, 32'h80000500, 32'h0, 1'b0);
    step;
    checkOutput("int_exccode", 32'(exccode_o), 32'h1F);
    checkOutput("int_busy", 32'(busy), 32'h1);
    applyStimulus(F_NONE, 1'b0, 32'h0, 32'h0, 1'b0);
    except_deal = 1'b1;
    step;
    checkOutput("deal_in_report_ignored", 32'(flush), 32'h0);
    step;
    except_deal = 1'b0;
    checkOutput("int_redirect_pc", redirect_pc, 32'hBFC00380);
    step;

    // Fetch AdEL beats RI; badaddr is the PC
    applyStimulus(F_ADEL_IF | F_RI, 1'b1, 32'h80000601, 32'h55555555, 1'b0);
    step;
    checkOutput("adelif_exccode", 32'(exccode_o), 32'h04);
    checkOutput("adelif_badaddr", badaddr_o, 32'h80000601);
    applyStimulus(F_NONE, 1'b0, 32'h0, 32'h0, 1'b0);
    ackAndDrain;

    // Invalid instruction and stalled requests are not captured
    applyStimulus(F_BP, 1'b0, 32'h80000700, 32'h0, 1'b0);
    step;
    checkOutput("invalid_no_capture", 32'(busy), 32'h0);
    applyStimulus(F_OV, 1'b1, 32'h80000800, 32'h0, 1'b0);
    stall_in = 1'b1;
    step;
    checkOutput("stall_no_capture1", 32'(busy), 32'h0);
    step;
    checkOutput("stall_no_capture2", 32'(busy), 32'h0);
    stall_in = 1'b0;
    step;
    checkOutput("unstall_capture", 32'(busy), 32'h1);
    checkOutput("unstall_pc_o", pc_o, 32'h80000800);
    applyStimulus(F_NONE, 1'b0, 32'h0, 32'h0, 1'b0);
    ackAndDrain;

    // Syscall with no acknowledge times out
    applyStimulus(F_SYS, 1'b1, 32'h80000900, 32'h0, 1'b0);
    step;
    checkOutput("sys_exccode", 32'(exccode_o), 32'h08);
    applyStimulus(F_NONE, 1'b0, 32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step;
      checkOutput("sys_ack_err_early", 32'(ack_err), 32'h0);
      checkOutput("sys_no_flush", 32'(flush), 32'h0);
    end
    step;
    checkOutput("sys_ack_err_pulse", 32'(ack_err), 32'h1);
    checkOutput("sys_busy_last", 32'(busy), 32'h1);
    step;
    checkOutput("sys_ack_err_done", 32'(ack_err), 32'h0);
    checkOutput("sys_busy_after", 32'(busy), 32'h0);
    checkOutput("sys_flush_after", 32'(flush), 32'h0);
    checkOutput("sys_exccode_after", 32'(exccode_o), 32'h1F);

    // Asynchronous reset in WAIT_ACK, then capture right after release
    applyStimulus(F_BP, 1'b1, 32'h80000A00, 32'h0, 1'b1);
    step;
    checkOutput("bp_exccode", 32'(exccode_o), 32'h09);
    applyStimulus(F_NONE, 1'b0, 32'h0, 32'h0, 1'b0);
    step;
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_exccode", 32'(exccode_o), 32'h1F);
    checkOutput("arst_busy", 32'(busy), 32'h0);
    checkOutput("arst_pc_o", pc_o, 32'h0);
    checkOutput("arst_dslot", 32'(dslot_o), 32'h0);
    checkOutput("arst_badaddr", badaddr_o, 32'h0);
    step;
    rst = 1'b0;
    applyStimulus(F_OV, 1'b1, 32'h80000B00, 32'h0, 1'b0);
    step;
    checkOutput("post_rst_capture", 32'(busy), 32'h1);
    checkOutput("post_rst_exccode", 32'(exccode_o), 32'h0C);
    applyStimulus(F_NONE, 1'b0, 32'h0, 32'h0, 1'b0);
    ackAndDrain;
    checkOutput("final_idle", 32'(busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
